// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcodes, format encoding and decoded bundle for the decode stage
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_e;

    // Widest form of a decoded instruction; narrower datapaths keep their own
    // width-matched copy so no storage bits go unused.
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
        logic [63:0] pc;
    } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational format classifier and sign-extended immediate builder
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ins,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    fmt_e        fmt_s;
    logic [31:0] low32;

    // Classify by opcode; the W-suffixed opcodes only exist on a 64-bit datapath
    always_comb begin
        fmt_s = FMT_BAD;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                OP_OP:     fmt_s = FMT_R;
                OP_OP_32:  fmt_s = (XLEN == 64) ? FMT_R : FMT_BAD;
                OP_LOAD,
                OP_IMM,
                OP_JALR,
                OP_SYSTEM: fmt_s = FMT_I;
                OP_IMM_32: fmt_s = (XLEN == 64) ? FMT_I : FMT_BAD;
                OP_STORE:  fmt_s = FMT_S;
                OP_BRANCH: fmt_s = FMT_B;
                OP_LUI,
                OP_AUIPC:  fmt_s = FMT_U;
                OP_JAL:    fmt_s = FMT_J;
                default:   fmt_s = FMT_BAD;
            endcase
        end
    end

    // Build the low 32 bits, then replicate bit 31 upward; R and BAD leave zero
    always_comb begin
        low32 = 32'd0;
        case (fmt_s)
            FMT_I:   low32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   low32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   low32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   low32 = {ins[31:12], 12'b0};
            FMT_J:   low32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: low32 = 32'd0;
        endcase
        imm        = {XLEN{low32[31]}};
        imm[31:0]  = low32;
    end

    assign fmt     = fmt_s;
    assign illegal = (fmt_s == FMT_BAD);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with in-order output queue and flush
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_op,
    output logic [2:0]      out_f3,
    output logic [6:0]      out_f7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [2:0]      gen_fmt;
    logic [XLEN-1:0] gen_imm;
    logic            gen_illegal;
    entry_t          new_entry;
    entry_t          head;
    logic            push;
    logic            pop;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ins     (in_ins),
        .fmt     (gen_fmt),
        .imm     (gen_imm),
        .illegal (gen_illegal)
    );

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Assemble the decoded bundle for the incoming instruction
    always_comb begin
        new_entry         = '0;
        new_entry.op      = in_ins[6:0];
        new_entry.f3      = in_ins[14:12];
        new_entry.f7      = in_ins[31:25];
        new_entry.rs1     = in_ins[19:15];
        new_entry.rs2     = in_ins[24:20];
        new_entry.rd      = in_ins[11:7];
        new_entry.imm     = gen_imm;
        new_entry.fmt     = gen_fmt;
        new_entry.illegal = gen_illegal;
        new_entry.pc      = in_pc;
    end

    // Next-state for pointers, occupancy and storage; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state; reset also clears storage so every output reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_op      = head.op;
    assign out_f3      = head.f3;
    assign out_f7      = head.f7;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_pc      = head.pc;

endmodule
